// File: rtl/vec_angle_cordic_16bit.sv
// Vectoring-mode CORDIC: atan2(y, x) of a signed 16.16 vector as a 16-bit binary angle.
// Optional gain-corrected magnitude output is built when VEC_ANGLE_MAG_OUT_EN is defined.
module vec_angle_cordic_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    output logic [15:0] angle,
    output logic [31:0] magnitude,
    output logic        done,
    output logic        ready
);

    typedef enum logic [1:0] {StIdle, StIter, StDone} state_t;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic signed [33:0] x_q, x_d;
    logic signed [33:0] y_q, y_d;
    logic [15:0]        z_q, z_d;
    logic               zero_q, zero_d;
    logic [15:0]        angle_q, angle_d;
    // Low only while reset is held and in the cycle it is released.
    logic               live_q;

    logic signed [33:0] x_ext, y_ext;
    logic signed [33:0] x_shift, y_shift;
    logic [15:0]        atan_i;
    logic               accept;
    logic               finish;

    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_lut = 16'd8192;
            4'd1:    atan_lut = 16'd4836;
            4'd2:    atan_lut = 16'd2555;
            4'd3:    atan_lut = 16'd1297;
            4'd4:    atan_lut = 16'd651;
            4'd5:    atan_lut = 16'd326;
            4'd6:    atan_lut = 16'd163;
            4'd7:    atan_lut = 16'd81;
            4'd8:    atan_lut = 16'd41;
            4'd9:    atan_lut = 16'd20;
            4'd10:   atan_lut = 16'd10;
            4'd11:   atan_lut = 16'd5;
            4'd12:   atan_lut = 16'd3;
            4'd13:   atan_lut = 16'd1;
            4'd14:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

    assign x_ext   = {{2{x_in[31]}}, x_in};
    assign y_ext   = {{2{y_in[31]}}, y_in};
    assign x_shift = x_q >>> cnt_q[3:0];
    assign y_shift = y_q >>> cnt_q[3:0];
    assign atan_i  = atan_lut(cnt_q[3:0]);

    assign ready  = live_q && (state_q != StIter);
    assign done   = (state_q == StDone);
    assign accept = ready && start;
    // cnt_q reaches 16 one cycle after the last micro-rotation.
    assign finish = (state_q == StIter) && cnt_q[4];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        zero_d  = zero_q;
        angle_d = angle_q;

        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (accept) begin
                    cnt_d  = '0;
                    // The iterations would otherwise accumulate every ATAN term for (0,0).
                    zero_d = (x_in == 32'd0) && (y_in == 32'd0);
                    if (x_ext[33]) begin
                        x_d = -x_ext;
                        y_d = -y_ext;
                        z_d = 16'd32768;
                    end else begin
                        x_d = x_ext;
                        y_d = y_ext;
                        z_d = 16'd0;
                    end
                    state_d = StIter;
                end
            end
            StIter: begin
                if (finish) begin
                    angle_d = zero_q ? 16'd0 : z_q;
                    state_d = StDone;
                end else begin
                    if (!y_q[33]) begin
                        x_d = x_q + y_shift;
                        y_d = y_q - x_shift;
                        z_d = z_q + atan_i;
                    end else begin
                        x_d = x_q - y_shift;
                        y_d = y_q + x_shift;
                        z_d = z_q - atan_i;
                    end
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            live_q  <= 1'b1;
        end
    end

    assign angle = angle_q;

`ifdef VEC_ANGLE_MAG_OUT_EN
    logic [31:0] mag_q;

    // 39797/65536 ~= 0.607253 removes the CORDIC gain; x_q is non-negative here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_q <= '0;
        end else if (finish) begin
            mag_q <= 32'(({16'd0, x_q} * 50'd39797) >> 16);
        end
    end

    assign magnitude = mag_q;
`else
    assign magnitude = 32'd0;
`endif

endmodule

// File: tb/tb_vec_angle_cordic_16bit.sv
// Directed bench for vec_angle_cordic_16bit: reset, latency, axis/diagonal angles,
// back-to-back starts, reset mid-operation and the zero / most-negative corner cases.
module tb_vec_angle_cordic_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] x_in;
    logic [31:0] y_in;
    logic [15:0] angle;
    logic [31:0] magnitude;
    logic        done;
    logic        ready;

    int tests;
    int fails;

    vec_angle_cordic_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .x_in      (x_in),
        .y_in      (y_in),
        .angle     (angle),
        .magnitude (magnitude),
        .done      (done),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Angle within +/-2 LSB, modulo 65536.
    task automatic check_angle(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        logic [15:0] d;
        logic        ok;
        d  = obs - exp;
        ok = (d <= 16'd2) || (d >= 16'hFFFE);
        tests++;
        assert (ok === 1'b1) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d+/-2", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT ready; returns edges from accept until done is seen.
    task automatic run_op(input logic [31:0] xv, input logic [31:0] yv, output int lat);
        start = 1'b1;
        x_in  = xv;
        y_in  = yv;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] xv, input logic [31:0] yv,
                            input logic [15:0] exp_angle);
        int lat;
        run_op(xv, yv, lat);
        check({tag, "_latency"}, lat, 17);
        check_angle({tag, "_angle"}, angle, exp_angle);
        @(posedge clk); #1;
    endtask

    initial begin
        int lat;
        int ndone;
        int first_done;
        int bad_ready;
        logic [15:0] held;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        start = 1'b1;
        x_in  = 32'h0001_0000;
        y_in  = 32'd0;

        // Reset held with start asserted: nothing may be accepted.
        repeat (3) @(posedge clk);
        #1;
        check("rst_angle", angle, 0);
        check("rst_magnitude", magnitude, 0);
        check("rst_done", done, 0);
        check("rst_ready", ready, 0);

        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", ready, 1);
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_ready_no_accept", ready, 1);

        // +x axis, with explicit magnitude for this build.
        run_op(32'h0001_0000, 32'd0, lat);
        check("px_latency", lat, 17);
        check_angle("px_angle", angle, 16'd0);
        check("px_done_ready", ready, 1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);

        op_check("py", 32'd0, 32'h0001_0000, 16'd16384);
        op_check("nx", 32'hFFFF_0000, 32'd0, 16'd32768);
        op_check("ny", 32'd0, 32'hFFFF_0000, 16'd49152);
        op_check("diag", 32'h0000_B505, 32'h0000_B505, 16'd8192);

        // 3-4-5 triangle: atan2(4,3) = 0.92730 rad -> 9672 LSB.
        run_op(32'h0003_0000, 32'h0004_0000, lat);
        check("t345_latency", lat, 17);
        check_angle("t345_angle", angle, 16'd9672);
`ifdef VEC_ANGLE_MAG_OUT_EN
        begin
            longint md;
            md = longint'(magnitude) - 64'h5_0000;
            check("t345_magnitude_close", (md >= -8 && md <= 8) ? 1 : 0, 1);
        end
`else
        check("t345_magnitude_zero", magnitude, 0);
`endif
        held = angle;
        repeat (3) @(posedge clk);
        #1;
        check("angle_hold", angle, held);
        check("done_low_idle", done, 0);

        run_op(32'd0, 32'd0, lat);
        check("zero_latency", lat, 17);
        check("zero_angle", angle, 0);
        check("zero_magnitude", magnitude, 0);
        @(posedge clk); #1;

        op_check("most_neg", 32'h8000_0000, 32'd0, 16'd32768);

        // start held high for 40 cycles.
        ndone      = 0;
        first_done = -1;
        bad_ready  = 0;
        start = 1'b1;
        x_in  = 32'd0;
        y_in  = 32'h0001_0000;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
            if (ready && !done) bad_ready++;
        end
        start = 1'b0;
        check("b2b_done_count", ndone, 2);
        check("b2b_first_done", first_done, 17);
        check("b2b_ready_low_in_iter", bad_ready, 0);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_tail_done_seen", done, 1);
        check_angle("b2b_angle", angle, 16'd16384);
        @(posedge clk); #1;

        // Reset sampled at edge N+8 of an operation.
        start = 1'b1;
        x_in  = 32'h0001_0000;
        y_in  = 32'h0001_0000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_angle", angle, 0);
        check("midrst_magnitude", magnitude, 0);
        check("midrst_done", done, 0);
        check("midrst_ready", ready, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        op_check("after_rst", 32'd0, 32'hFFFF_0000, 16'd49152);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
